// File: rtl/clangpu_inst_rom_axi.sv
// AXI4 read-only instruction/constant ROM for the ClangPU fetch unit, filled through a host load port.
// Optional out-of-range SLVERR response is enabled by defining CLANGPU_ROM_RANGE_CHK_EN.
module clangpu_inst_rom_axi #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_OFFSET_WIDTH   = 32,
    parameter int MEM_ADDR_WIDTH   = 12
) (
    input  logic                        AXI_CLK,
    input  logic                        AXI_RST,
    input  logic [C_OFFSET_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [7:0]                  S_AXI_ARLEN,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RLAST,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    input  logic                        LD_WE,
    input  logic [MEM_ADDR_WIDTH-1:0]   LD_ADDR,
    input  logic [31:0]                 LD_DATA
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                      state_q, state_d;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]                  cnt_q, cnt_d;
    logic                        fixed_q, fixed_d;
    logic                        err_q, err_d;
    logic                        arEn_q;
    logic [C_AXI_DATA_WIDTH-1:0] mem [DEPTH];
    logic [C_AXI_DATA_WIDTH-1:0] memRd_q;
    logic                        rdEn;
    logic [MEM_ADDR_WIDTH-1:0]   rdAddr;
    logic                        upperHit;
    logic                        rangeErr;
    logic                        arHs;
    logic                        rHs;
    logic                        lastBeat;
    logic                        unusedBits;

    assign upperHit = |S_AXI_ARADDR[C_OFFSET_WIDTH-1:MEM_ADDR_WIDTH+2];

`ifdef CLANGPU_ROM_RANGE_CHK_EN
    assign rangeErr   = upperHit;
    assign unusedBits = ^S_AXI_ARADDR[1:0];
`else
    // Upper address bits alias modulo the memory size.
    assign rangeErr   = 1'b0;
    assign unusedBits = ^{upperHit, S_AXI_ARADDR[1:0]};
`endif

    assign S_AXI_ARREADY = (state_q == IDLE) && arEn_q;
    assign S_AXI_RVALID  = (state_q == DATA);
    assign lastBeat      = (cnt_q == 8'd0);
    assign S_AXI_RLAST   = S_AXI_RVALID && lastBeat;
    assign S_AXI_RRESP   = (S_AXI_RVALID && err_q) ? 2'b10 : 2'b00;
    assign S_AXI_RDATA   = err_q ? '0 : memRd_q;
    assign arHs          = S_AXI_ARVALID && S_AXI_ARREADY;
    assign rHs           = S_AXI_RVALID && S_AXI_RREADY;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        fixed_d = fixed_q;
        err_d   = err_q;
        rdEn    = 1'b0;
        rdAddr  = addr_q;
        case (state_q)
            IDLE: begin
                if (arHs) begin
                    addr_d  = S_AXI_ARADDR[MEM_ADDR_WIDTH+1:2];
                    cnt_d   = S_AXI_ARLEN;
                    fixed_d = (S_AXI_ARBURST == 2'b00);
                    err_d   = rangeErr;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                rdEn    = !err_q;
                state_d = DATA;
            end
            DATA: begin
                // The next beat's address is read in the handshake cycle to sustain one beat per cycle.
                if (rHs) begin
                    if (lastBeat) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                        if (!fixed_q) begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                        rdAddr = addr_d;
                        rdEn   = !err_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge AXI_CLK) begin
        if (AXI_RST) begin
            state_q <= IDLE;
            arEn_q  <= 1'b0;
            addr_q  <= '0;
            cnt_q   <= 8'd0;
            fixed_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arEn_q  <= 1'b1;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            fixed_q <= fixed_d;
            err_q   <= err_d;
        end
    end

    // Read-first memory; no reset so host loads land even while AXI_RST is held.
    always_ff @(posedge AXI_CLK) begin
        if (LD_WE) begin
            mem[LD_ADDR] <= LD_DATA;
        end
        if (rdEn) begin
            memRd_q <= mem[rdAddr];
        end
    end

endmodule
